// File: rtl/dem_pkg.sv
// Shared definitions for the tree-structured DEM: LFSR constants, steering values
// and the saturating clamp used by every shaping loop.
package dem_pkg;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form (bits 0,2,3,5)
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    localparam logic signed [1:0] S_POS  = 2'sb01;
    localparam logic signed [1:0] S_NEG  = 2'sb11;
    localparam logic signed [1:0] S_ZERO = 2'sb00;

    function automatic int sat_s(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/dem_lfsr16.sv
// 16-bit Fibonacci LFSR advancing once per enable; bit 0 is the dither source.
module dem_lfsr16
    import dem_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [15:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= SEED;
        else if (en)
            state <= {^(state & LFSR_TAPS), state[15:1]};
    end

endmodule

// File: rtl/decp_gen_param.sv
// Decouple sequence generator: splits v into gama+beta, steering odd-count
// imbalance with a 1st/2nd-order noise-shaped +/-1 sequence.
module decp_gen_param
    import dem_pkg::*;
#(
    parameter int          N         = 8,
    parameter int          ORDER     = 1,
    parameter int          ACC_W     = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    localparam int         VW        = $clog2(N) + 1,
    localparam int         GW        = $clog2(N)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clk_en,
    input  logic [VW-1:0]       v,
    input  logic                dither_en,
    input  logic                dither_ext_sel,
    input  logic signed [1:0]   dither_ext,
    input  logic                ord2_en,
    output logic [GW-1:0]       gama,
    output logic [GW-1:0]       beta,
    output logic signed [1:0]   s_out,
    output logic                out_valid,
    output logic                in_clip,
    output logic                acc_sat
);

    localparam bit HAS_ORD2 = (ORDER >= 2);

    logic signed [ACC_W-1:0] e1, e2;
    logic [15:0]             lfsr;
    logic                    unused_lfsr_hi;

    logic                    ord2;
    logic                    clip;
    logic [VW-1:0]           vc;
    logic [GW-1:0]           half;
    logic signed [1:0]       d;
    logic signed [ACC_W+1:0] d_x, e1_x, e2_x, u;
    logic signed [1:0]       s;
    logic [GW-1:0]           gama_nx, beta_nx;
    int                      e1_raw, e1_sat, e2_raw, e2_sat;
    logic signed [ACC_W-1:0] e1_nx, e2_nx;
    logic                    sat_nx;

    dem_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .en    (clk_en),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:1];
    assign ord2 = HAS_ORD2 & ord2_en;
    assign clip = (v > VW'(N));
    assign vc   = clip ? VW'(N) : v;
    assign half = vc[VW-1:1];

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        d = S_ZERO;
        if (dither_en)
            d = dither_ext_sel ? dither_ext : {lfsr[0], lfsr[0]};

        d_x  = {{ACC_W{d[1]}}, d};
        e1_x = {{2{e1[ACC_W-1]}}, e1};
        e2_x = ord2 ? {{2{e2[ACC_W-1]}}, e2} : '0;
        u    = d_x + e1_x + e2_x;

        // Zero maps to +1; only odd counts carry an imbalance to steer
        s = S_ZERO;
        if (vc[0])
            s = u[ACC_W+1] ? S_NEG : S_POS;

        gama_nx = half;
        beta_nx = half;
        if (s == S_POS)
            beta_nx = half + GW'(1);
        else if (s == S_NEG)
            gama_nx = half + GW'(1);

        e1_raw = int'(e1) - int'(s);
        e1_sat = sat_s(e1_raw, ACC_W);
        e2_raw = ord2 ? int'(e2) + e1_sat : 0;
        e2_sat = sat_s(e2_raw, ACC_W);
        e1_nx  = e1_sat[ACC_W-1:0];
        e2_nx  = e2_sat[ACC_W-1:0];
        sat_nx = (e1_sat != e1_raw) || (e2_sat != e2_raw);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e1        <= '0;
            e2        <= '0;
            gama      <= '0;
            beta      <= '0;
            s_out     <= S_ZERO;
            out_valid <= 1'b0;
            in_clip   <= 1'b0;
            acc_sat   <= 1'b0;
        end else begin
            out_valid <= clk_en;
            if (clk_en) begin
                e1      <= e1_nx;
                e2      <= e2_nx;
                gama    <= gama_nx;
                beta    <= beta_nx;
                s_out   <= s;
                in_clip <= clip;
                acc_sat <= sat_nx;
            end
        end
    end

endmodule
